// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the adder/subtractor family: default width
// and the sequencer state encoding.
package arith_pkg;
  localparam int ADD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arith_state_e;
endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_8bit_with_enable.sv
// Bit-serial subtractor, LSB first. start/done handshake; enable freezes all state.
// Handshake: start is taken on an enabled edge in IDLE or DONE; done marks one result.
module serial_subtractor_8bit_with_enable
  import arith_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             fs_d, fs_bout;

  full_subtractor_1bit u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    if (enable) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          res_d = {fs_d, res_q[WIDTH-1:1]};
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          br_d  = fs_bout;
          cnt_d = cnt_q + 1'b1;
          // Last bit: publish the result and leave RUN before the counter can wrap.
          if (cnt_q == LAST) begin
            diff_d  = {fs_d, res_q[WIDTH-1:1]};
            bout_d  = fs_bout;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor_8bit_with_enable.sv
// Bench for the serial subtractor: directed timing cases plus a random regression,
// with results checked by a queue-based scoreboard.
module tb_serial_subtractor_8bit_with_enable;
  logic       clk;
  logic       rst;
  logic       enable;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor_8bit_with_enable #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bout   (bout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
    int d;
    logic [7:0] dd;
    logic br;
    d  = int'(ta) - int'(tb_v) - int'(tbin);
    dd = d[7:0];
    br = (int'(ta) < int'(tb_v) + int'(tbin));
    return {br, dd};
  endfunction

  // Hold start with operands until an enabled edge sees the DUT idle or done.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       input int gap, output int waited);
    logic will;
    logic accepted;
    accepted = 1'b0;
    waited = 0;
    a = ta;
    b = tb_v;
    bin = tbin;
    start = 1'b1;
    while (!accepted && waited < 200) begin
      enable = (int'($urandom_range(0, 99)) >= gap);
      will = enable && !busy && !rst;
      @(posedge clk);
      #2;
      waited++;
      if (will) accepted = 1'b1;
    end
    start = 1'b0;
    if (accepted) exp_q.push_back(model(ta, tb_v, tbin));
    else check("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic wait_done(output int m);
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
    end while (!done && m < 100);
    check("done_seen", 32'(done), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    #1;
  endtask

  // Scoreboard monitor: a result is new when done is high after an enabled, non-reset edge.
  initial begin
    logic en_prev;
    logic rst_prev;
    logic [8:0] e;
    en_prev = 1'b0;
    rst_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (done && en_prev && !rst_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got 0x%0h with nothing queued", {bout, diff});
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({bout, diff}), 32'(e));
        end
      end
      en_prev = enable;
      rst_prev = rst;
    end
  end

  initial begin
    int w;
    int m;
    int n;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    va[0] = 8'h00; vb[0] = 8'h01; vc[0] = 1'b0;
    va[1] = 8'hFF; vb[1] = 8'h00; vc[1] = 1'b0;
    va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b1;

    rst = 1'b1;
    enable = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    #1;
    rst = 1'b0;

    // Basic vectors with enable held high: latency and single-cycle done.
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vc[i], 0, w);
      wait_done(m);
      check("latency", 32'(m), 32'd8);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      #1;
    end

    // Three-cycle stall mid-RUN.
    issue(8'hF0, 8'h0F, 1'b0, 0, w);
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #2;
      n++;
    end
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      n++;
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_diff_hold", 32'(diff), 32'hFF);
      #1;
    end
    enable = 1'b1;
    wait_done(m);
    check("stall_latency", 32'(n + m), 32'd11);

    // start during RUN is ignored; start in DONE runs back-to-back.
    issue(8'h3C, 8'h5A, 1'b1, 0, w);
    @(posedge clk);
    #2;
    start = 1'b1;
    a = 8'h55;
    b = 8'h11;
    bin = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    wait_done(m);
    check("ignore_latency", 32'(m), 32'd5);
    issue(8'h80, 8'h80, 1'b0, 0, w);
    check("back_to_back_accept", 32'(w), 32'd1);
    wait_done(m);
    check("back_to_back_latency", 32'(m), 32'd8);

    // Reset mid-operation abandons the result.
    issue(8'h12, 8'h34, 1'b0, 0, w);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    void'(exp_q.pop_back());
    #1;
    rst = 1'b0;
    issue(8'h77, 8'h22, 1'b0, 0, w);
    wait_done(m);
    check("post_reset_latency", 32'(m), 32'd8);

    // Random regression with random enable gaps.
    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), w);
    end
    enable = 1'b1;
    start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
